dmem_wait_responder: RTL and testbench
======================================

// Module: dmem_wait_responder
// PURPOSE
// - Data-memory responder for the CPU load/store port, using a valid/ready request and response handshake.
// - Serves one word access at a time.
// - Models a multi-cycle memory: a programmable number of wait states per read and per write.
// - Replaces the zero-wait dmem when the multicycle/pipelined CPU talks to a stalling memory.
// - The CPU side is the initiator. This block is the responder at the other end of that interface.
// PARAMETERS
// - DMEM_DEPTH       1024  number of 32-bit words stored
// - DMEM_ADDR_WIDTH  10    word-address width; must equal $clog2(DMEM_DEPTH)
// - RD_LATENCY       2     cycles from read accept to resp_valid; >=1, elaboration error otherwise
// - WR_LATENCY       1     cycles from write accept to resp_valid; >=1, elaboration error otherwise
// PORTS
// - clk        in   1                system clock; all state updates on posedge
// - reset_b    in   1                asynchronous active-low reset
// - req_valid  in   1                request present
// - req_ready  out  1                responder can accept a request
// - req_addr   in   DMEM_ADDR_WIDTH  word address
// - req_we     in   1                1 = store, 0 = load
// - req_wdata  in   32               store data
// - req_wstrb  in   4                byte enables for store; bit i selects wdata[8i+7:8i]
// - resp_valid out  1                response present
// - resp_ready in   1                initiator accepts response
// - resp_rdata out  32               load data; 32'h0 for store responses
// BEHAVIOUR
// - Reset (async, reset_b=0):
//   - state=IDLE, wait counter=0, captured request cleared, resp_valid=0, resp_rdata=0.
//   - req_ready=1 as soon as reset_b deasserts.
//   - The memory array is NOT reset.
// - FSM states: IDLE, WAIT, RESP.
// - IDLE:
//   - req_ready=1.
//   - Accept on the posedge with req_valid&req_ready.
//   - On accept, capture addr/we/wdata/wstrb and set LAT = req_we ? WR_LATENCY : RD_LATENCY.
//   - If LAT==1: perform the access on the accept edge and go to RESP.
//   - If LAT>1: load counter=LAT-2 and go to WAIT.
// - WAIT:
//   - req_ready=0; inputs are ignored.
//   - counter!=0: decrement.
//   - counter==0: perform the access on this edge and go to RESP.
// - Access:
//   - Store: write the enabled bytes only. wstrb=4'b0000 is a legal no-op and still produces a response.
//   - Load: register array[addr] into resp_rdata.
//   - Store: resp_rdata<=0.
// - Latency: resp_valid rises exactly LAT cycles after the accept edge.
// - RESP:
//   - resp_valid=1 and req_ready=0.
//   - resp_rdata is held stable until the handshake.
//   - On resp_valid&resp_ready: go to IDLE and clear resp_valid.
//   - A new request is accepted no earlier than the cycle after that edge.
//   - Throughput is at most 1 access per LAT+1 cycles.
// - Ordering: a load issued after a completed store to the same address returns the stored bytes. There is no forwarding requirement because only one access is outstanding.
// - Address: the full range 0..DEPTH-1 is valid and there is no aliasing. Addresses do not wrap within an access (single word).
// - Reset mid-operation:
//   - A store in WAIT is discarded and the array is unchanged.
//   - A store already committed (in RESP) persists.
//   - A pending response is dropped.
// - req_* inputs may change freely while req_ready=0; they have no effect.
// STRUCTURE
// - Package dmem_pkg:
//   - typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t
//   - localparam WORD_WIDTH=32
//   - localparam STRB_WIDTH=4
//   - typedef struct {addr, we, wdata, wstrb} dmem_req_t
// - Sub-module dmem_byte_array:
//   - DMEM_DEPTH x 32 storage.
//   - Synchronous byte-enable write and registered read, both enabled by an access strobe.
//   - The FSM, counter and handshake live in the top.
// - Counter width: $clog2(max(RD_LATENCY,WR_LATENCY))+1.
// TESTING
// - Reset: hold reset_b=0 with random inputs -> resp_valid=0, resp_rdata=0; req_ready=1 the cycle after release.
// - Write/read: store 32'hDEADBEEF to addr 5 with wstrb=4'hF, then load addr 5 -> both responses occur; load resp_valid 2 cycles after accept; rdata=32'hDEADBEEF.
// - Byte strobe: after the above, store 32'h000000AA to addr 5 with wstrb=4'b0001; load -> 32'hDEADBEAA. A store with wstrb=0 leaves it unchanged.
// - Backpressure: hold resp_ready=0 for 5 cycles during a load response:
//   - resp_valid and rdata stay stable; req_ready=0.
//   - A concurrent req_valid is ignored.
//   - Release -> IDLE next cycle.
// - Reset mid-WAIT: addr 7 holds 32'h11111111. Issue a store of 32'h22222222 with WR_LATENCY=3 and pulse reset_b during WAIT -> a later load of addr 7 returns 32'h11111111.
// - Address extremes: store distinct values to addr 0 and 1023 -> loads return each value with no aliasing. Sweep RD_LATENCY=1 for the direct IDLE->RESP path.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and widths for the wait-state data-memory responder.
// Contents: word/strobe/address widths, FSM state encoding, captured-request payload.
package dmem_pkg;

   localparam int unsigned WORD_WIDTH     = 32;
   localparam int unsigned STRB_WIDTH     = 4;
   localparam int unsigned REQ_ADDR_WIDTH = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   typedef struct packed {
      logic [REQ_ADDR_WIDTH-1:0] addr;
      logic                      we;
      logic [WORD_WIDTH-1:0]     wdata;
      logic [STRB_WIDTH-1:0]     wstrb;
   } dmem_req_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dmem_wait_responder_if.sv
// Load/store port between the CPU (master) and the data-memory responder (slave).
// Request: req_valid/req_ready handshake carrying addr, we, wdata, wstrb.
// Response: resp_valid/resp_ready handshake carrying rdata.
interface dmem_wait_responder_if #(
   parameter int unsigned ADDR_WIDTH = 10
);

   logic                              req_valid;
   logic                              req_ready;
   logic [ADDR_WIDTH-1:0]             req_addr;
   logic                              req_we;
   logic [dmem_pkg::WORD_WIDTH-1:0]   req_wdata;
   logic [dmem_pkg::STRB_WIDTH-1:0]   req_wstrb;
   logic                              resp_valid;
   logic                              resp_ready;
   logic [dmem_pkg::WORD_WIDTH-1:0]   resp_rdata;

   modport master (
      output req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata
   );

endinterface

// File: rtl/dmem_byte_array.sv
// Word storage with byte-enable writes and a registered read, both qualified by acc_en.
// Ports: clk, reset_b (clears only the read register), acc_en (access strobe), we,
//        addr, wdata, wstrb (inputs); rdata (registered: array word on load, 0 on store).
module dmem_byte_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset_b,
   input  logic                  acc_en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WORD_WIDTH-1:0] wdata,
   input  logic [STRB_WIDTH-1:0] wstrb,
   output logic [WORD_WIDTH-1:0] rdata
);

   logic [WORD_WIDTH-1:0] mem [DEPTH];

   // Storage is never reset; writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (reset_b && acc_en && we) begin
         for (int b = 0; b < int'(STRB_WIDTH); b++) begin
            if (wstrb[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // Read register doubles as the response data; store responses return zero.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rdata <= '0;
      end else if (acc_en) begin
         rdata <= we ? '0 : mem[addr];
      end
   end

endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with programmable read/write wait states, one access in flight.
// Ports: clk, reset_b (async active-low), bus (slave side of dmem_wait_responder_if).
// A request accepted in IDLE is served after RD_LATENCY/WR_LATENCY cycles, then held
// in RESP until the initiator takes the response.
module dmem_wait_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DMEM_DEPTH      = 1024,
   parameter int unsigned DMEM_ADDR_WIDTH = 10,
   parameter int unsigned RD_LATENCY      = 2,
   parameter int unsigned WR_LATENCY      = 1
) (
   input logic                  clk,
   input logic                  reset_b,
   dmem_wait_responder_if.slave bus
);

   localparam int unsigned MAX_LAT   = max_u(RD_LATENCY, WR_LATENCY);
   localparam int unsigned CNT_WIDTH = $clog2(MAX_LAT) + 1;

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_WAIT = 2'(WAIT);
   localparam logic [1:0] ST_RESP = 2'(RESP);

   // Counter preload for multi-cycle accesses (counter runs LAT-2 .. 0 in WAIT).
   localparam logic [CNT_WIDTH-1:0] RD_PRELOAD = CNT_WIDTH'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
   localparam logic [CNT_WIDTH-1:0] WR_PRELOAD = CNT_WIDTH'((WR_LATENCY > 1) ? WR_LATENCY - 2 : 0);
   localparam logic RD_SINGLE = (RD_LATENCY == 1);
   localparam logic WR_SINGLE = (WR_LATENCY == 1);

   // Elaboration-time parameter checks.
   if (RD_LATENCY < 1) begin : g_bad_rd_latency
      $error("RD_LATENCY must be >= 1");
   end
   if (WR_LATENCY < 1) begin : g_bad_wr_latency
      $error("WR_LATENCY must be >= 1");
   end
   if (DMEM_ADDR_WIDTH != $clog2(DMEM_DEPTH)) begin : g_bad_addr_width
      $error("DMEM_ADDR_WIDTH must equal $clog2(DMEM_DEPTH)");
   end
   if (DMEM_ADDR_WIDTH != REQ_ADDR_WIDTH) begin : g_bad_pkg_width
      $error("DMEM_ADDR_WIDTH must match dmem_pkg::REQ_ADDR_WIDTH");
   end

   logic [1:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   dmem_req_t            cap_q, cap_d;
   logic                 req_ready_q, req_ready_d;
   logic                 resp_valid_q, resp_valid_d;

   logic                 acc_c;
   logic                 use_in_c;
   logic                 single_c;
   logic [WORD_WIDTH-1:0] rdata;

   // State and handshake registers.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cap_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cap_q        <= cap_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   assign single_c = bus.req_we ? WR_SINGLE : RD_SINGLE;

   // Next-state, counter, capture and access-strobe decode.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cap_d        = cap_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      acc_c        = 1'b0;
      use_in_c     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               cap_d.addr  = bus.req_addr;
               cap_d.we    = bus.req_we;
               cap_d.wdata = bus.req_wdata;
               cap_d.wstrb = bus.req_wstrb;
               req_ready_d = 1'b0;
               if (single_c) begin
                  // Single-cycle access uses the live request, not the capture.
                  acc_c        = 1'b1;
                  use_in_c     = 1'b1;
                  resp_valid_d = 1'b1;
                  state_d      = ST_RESP;
               end else begin
                  cnt_d   = bus.req_we ? WR_PRELOAD : RD_PRELOAD;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end else begin
               acc_c        = 1'b1;
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b0;
         end
      endcase
   end

   dmem_byte_array #(
      .DEPTH      (DMEM_DEPTH),
      .ADDR_WIDTH (DMEM_ADDR_WIDTH)
   ) u_array (
      .clk     (clk),
      .reset_b (reset_b),
      .acc_en  (acc_c),
      .we      (use_in_c ? bus.req_we    : cap_q.we),
      .addr    (use_in_c ? bus.req_addr  : cap_q.addr),
      .wdata   (use_in_c ? bus.req_wdata : cap_q.wdata),
      .wstrb   (use_in_c ? bus.req_wstrb : cap_q.wstrb),
      .rdata   (rdata)
   );

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = rdata;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: three instances cover the default latencies
// (RD=2, WR=1), single-cycle reads (RD=1, WR=1) and multi-cycle writes (RD=2, WR=3).
module tb_dmem_wait_responder;

   localparam int unsigned AW = 10;
   localparam int unsigned N  = 3;

   logic clk;
   logic reset_b;

   logic          req_valid_d [N];
   logic [AW-1:0] req_addr_d  [N];
   logic          req_we_d    [N];
   logic [31:0]   req_wdata_d [N];
   logic [3:0]    req_wstrb_d [N];
   logic          resp_ready_d[N];
   logic          req_ready_o [N];
   logic          resp_valid_o[N];
   logic [31:0]   resp_rdata_o[N];

   int errors;
   int checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dmem_wait_responder_if #(.ADDR_WIDTH(AW)) bus0 ();
   dmem_wait_responder_if #(.ADDR_WIDTH(AW)) bus1 ();
   dmem_wait_responder_if #(.ADDR_WIDTH(AW)) bus2 ();

   assign bus0.req_valid = req_valid_d[0];  assign bus1.req_valid = req_valid_d[1];  assign bus2.req_valid = req_valid_d[2];
   assign bus0.req_addr  = req_addr_d[0];   assign bus1.req_addr  = req_addr_d[1];   assign bus2.req_addr  = req_addr_d[2];
   assign bus0.req_we    = req_we_d[0];     assign bus1.req_we    = req_we_d[1];     assign bus2.req_we    = req_we_d[2];
   assign bus0.req_wdata = req_wdata_d[0];  assign bus1.req_wdata = req_wdata_d[1];  assign bus2.req_wdata = req_wdata_d[2];
   assign bus0.req_wstrb = req_wstrb_d[0];  assign bus1.req_wstrb = req_wstrb_d[1];  assign bus2.req_wstrb = req_wstrb_d[2];
   assign bus0.resp_ready = resp_ready_d[0]; assign bus1.resp_ready = resp_ready_d[1]; assign bus2.resp_ready = resp_ready_d[2];
   assign req_ready_o[0]  = bus0.req_ready;  assign req_ready_o[1]  = bus1.req_ready;  assign req_ready_o[2]  = bus2.req_ready;
   assign resp_valid_o[0] = bus0.resp_valid; assign resp_valid_o[1] = bus1.resp_valid; assign resp_valid_o[2] = bus2.resp_valid;
   assign resp_rdata_o[0] = bus0.resp_rdata; assign resp_rdata_o[1] = bus1.resp_rdata; assign resp_rdata_o[2] = bus2.resp_rdata;

   dmem_wait_responder #(.DMEM_DEPTH(1024), .DMEM_ADDR_WIDTH(AW), .RD_LATENCY(2), .WR_LATENCY(1))
      u_dut0 (.clk(clk), .reset_b(reset_b), .bus(bus0));
   dmem_wait_responder #(.DMEM_DEPTH(1024), .DMEM_ADDR_WIDTH(AW), .RD_LATENCY(1), .WR_LATENCY(1))
      u_dut1 (.clk(clk), .reset_b(reset_b), .bus(bus1));
   dmem_wait_responder #(.DMEM_DEPTH(1024), .DMEM_ADDR_WIDTH(AW), .RD_LATENCY(2), .WR_LATENCY(3))
      u_dut2 (.clk(clk), .reset_b(reset_b), .bus(bus2));

   // One complete access: request handshake, count cycles to resp_valid, take the response.
   // lat counts negedge samples after the accept edge up to the first with resp_valid=1.
   task automatic access(input int d, input logic we, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input logic [3:0] st,
                         output logic [31:0] rd, output int lat);
      int n;
      @(negedge clk);
      req_we_d[d]    = we;
      req_addr_d[d]  = addr;
      req_wdata_d[d] = wd;
      req_wstrb_d[d] = st;
      req_valid_d[d] = 1'b1;
      n = 0;
      while (!req_ready_o[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready_o[d] !== 1'b1) begin
         errors++;
         $display("FAIL access_req_ready dut%0d addr=%0d: got %b, want 1", d, addr, req_ready_o[d]);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid_d[d] = 1'b0;
      lat = 1;
      while (!resp_valid_o[d] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = resp_rdata_o[d];
      resp_ready_d[d] = 1'b1;
      @(negedge clk);
      resp_ready_d[d] = 1'b0;
   endtask

   task automatic test_reset();
      reset_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_valid_d[0]  = 1'($urandom);
         req_we_d[0]     = 1'($urandom);
         req_addr_d[0]   = AW'($urandom);
         req_wdata_d[0]  = $urandom;
         req_wstrb_d[0]  = 4'($urandom);
         resp_ready_d[0] = 1'($urandom);
         checks++;
         if (resp_valid_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_valid cyc%0d: got %b, want 0", i, resp_valid_o[0]);
         end
         checks++;
         if (resp_rdata_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp_rdata cyc%0d: got %h, want 00000000", i, resp_rdata_o[0]);
         end
      end
      @(negedge clk);
      req_valid_d[0]  = 1'b0;
      resp_ready_d[0] = 1'b0;
      reset_b = 1'b1;
      @(negedge clk);
      for (int d = 0; d < int'(N); d++) begin
         checks++;
         if (req_ready_o[d] !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready dut%0d: got %b, want 1", d, req_ready_o[d]);
         end
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd;
      int lat;
      access(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF, rd, lat);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL wr_latency: got %0d, want 1", lat); end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h, want 00000000", rd); end
      access(0, 1'b0, 10'd5, 32'h0, 4'h0, rd, lat);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d, want 2", lat); end
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h, want deadbeef", rd); end
   endtask

   task automatic test_byte_strobe();
      logic [31:0] rd;
      int lat;
      access(0, 1'b1, 10'd5, 32'h000000AA, 4'b0001, rd, lat);
      access(0, 1'b0, 10'd5, 32'h0, 4'h0, rd, lat);
      checks++;
      if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL strobe_byte0: got %h, want deadbeaa", rd); end
      access(0, 1'b1, 10'd5, 32'h12345678, 4'b0000, rd, lat);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL strobe_zero_latency: got %0d, want 1", lat); end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL strobe_zero_rdata: got %h, want 00000000", rd); end
      access(0, 1'b0, 10'd5, 32'h0, 4'h0, rd, lat);
      checks++;
      if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL strobe_zero_noop: got %h, want deadbeaa", rd); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      int lat;
      @(negedge clk);
      req_we_d[0] = 1'b0; req_addr_d[0] = 10'd5; req_valid_d[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_d[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_valid_o[0] !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b, want 1", resp_valid_o[0]); end
      for (int i = 0; i < 5; i++) begin
         req_valid_d[0] = 1'b1; req_we_d[0] = 1'b1; req_addr_d[0] = 10'd5;
         req_wdata_d[0] = 32'h0; req_wstrb_d[0] = 4'hF;
         @(negedge clk);
         checks++;
         if (resp_valid_o[0] !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d: got %b, want 1", i, resp_valid_o[0]); end
         checks++;
         if (resp_rdata_o[0] !== 32'hDEADBEAA) begin errors++; $display("FAIL bp_rdata cyc%0d: got %h, want deadbeaa", i, resp_rdata_o[0]); end
         checks++;
         if (req_ready_o[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready cyc%0d: got %b, want 0", i, req_ready_o[0]); end
      end
      req_valid_d[0] = 1'b0;
      resp_ready_d[0] = 1'b1;
      @(negedge clk);
      resp_ready_d[0] = 1'b0;
      checks++;
      if (resp_valid_o[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b, want 0", resp_valid_o[0]); end
      checks++;
      if (req_ready_o[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b, want 1", req_ready_o[0]); end
      access(0, 1'b0, 10'd5, 32'h0, 4'h0, rd, lat);
      checks++;
      if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL bp_ignored_store: got %h, want deadbeaa", rd); end
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] rd;
      int lat;
      int n;
      access(2, 1'b1, 10'd7, 32'h11111111, 4'hF, rd, lat);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL w3_wr_latency: got %0d, want 3", lat); end
      access(2, 1'b0, 10'd7, 32'h0, 4'h0, rd, lat);
      checks++;
      if (rd !== 32'h11111111) begin errors++; $display("FAIL w3_preload: got %h, want 11111111", rd); end
      // Store 22222222 and abort it with reset while it sits in WAIT.
      @(negedge clk);
      req_we_d[2] = 1'b1; req_addr_d[2] = 10'd7; req_wdata_d[2] = 32'h22222222;
      req_wstrb_d[2] = 4'hF; req_valid_d[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_d[2] = 1'b0;
      checks++;
      if (req_ready_o[2] !== 1'b0) begin errors++; $display("FAIL w3_wait_ready: got %b, want 0", req_ready_o[2]); end
      reset_b = 1'b0;
      @(negedge clk);
      reset_b = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (resp_valid_o[2] !== 1'b0) begin errors++; $display("FAIL w3_dropped_valid: got %b, want 0", resp_valid_o[2]); end
      access(2, 1'b0, 10'd7, 32'h0, 4'h0, rd, lat);
      checks++;
      if (rd !== 32'h11111111) begin errors++; $display("FAIL w3_discarded_store: got %h, want 11111111", rd); end
      // Store 33333333 to addr 8, reach RESP, then reset before the handshake.
      @(negedge clk);
      req_we_d[2] = 1'b1; req_addr_d[2] = 10'd8; req_wdata_d[2] = 32'h33333333;
      req_wstrb_d[2] = 4'hF; req_valid_d[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_d[2] = 1'b0;
      n = 0;
      while (!resp_valid_o[2] && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (resp_valid_o[2] !== 1'b1) begin errors++; $display("FAIL w3_commit_valid: got %b, want 1", resp_valid_o[2]); end
      reset_b = 1'b0;
      #1;
      checks++;
      if (resp_valid_o[2] !== 1'b0) begin errors++; $display("FAIL w3_async_drop: got %b, want 0", resp_valid_o[2]); end
      @(negedge clk);
      reset_b = 1'b1;
      access(2, 1'b0, 10'd8, 32'h0, 4'h0, rd, lat);
      checks++;
      if (rd !== 32'h33333333) begin errors++; $display("FAIL w3_committed_store: got %h, want 33333333", rd); end
   endtask

   task automatic test_addr_extremes();
      logic [31:0] rd;
      int lat;
      access(0, 1'b1, 10'd0,    32'hA5A50F0F, 4'hF, rd, lat);
      access(0, 1'b1, 10'd1023, 32'h5A5AF0F0, 4'hF, rd, lat);
      access(0, 1'b0, 10'd0, 32'h0, 4'h0, rd, lat);
      checks++;
      if (rd !== 32'hA5A50F0F) begin errors++; $display("FAIL addr0: got %h, want a5a50f0f", rd); end
      access(0, 1'b0, 10'd1023, 32'h0, 4'h0, rd, lat);
      checks++;
      if (rd !== 32'h5A5AF0F0) begin errors++; $display("FAIL addr1023: got %h, want 5a5af0f0", rd); end
   endtask

   task automatic test_rd_latency1();
      logic [31:0] rd;
      int lat;
      access(1, 1'b1, 10'd1023, 32'h0BADF00D, 4'hF, rd, lat);
      access(1, 1'b1, 10'd0,    32'h12345678, 4'hF, rd, lat);
      access(1, 1'b0, 10'd1023, 32'h0, 4'h0, rd, lat);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL r1_latency: got %0d, want 1", lat); end
      checks++;
      if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL r1_addr1023: got %h, want 0badf00d", rd); end
      access(1, 1'b0, 10'd0, 32'h0, 4'h0, rd, lat);
      checks++;
      if (rd !== 32'h12345678) begin errors++; $display("FAIL r1_addr0: got %h, want 12345678", rd); end
      // Partial strobe on the single-cycle path: upper two bytes only.
      access(1, 1'b1, 10'd0, 32'hFFFF0000, 4'b1100, rd, lat);
      access(1, 1'b0, 10'd0, 32'h0, 4'h0, rd, lat);
      checks++;
      if (rd !== 32'hFFFF5678) begin errors++; $display("FAIL r1_strobe: got %h, want ffff5678", rd); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset_b = 1'b0;
      for (int d = 0; d < int'(N); d++) begin
         req_valid_d[d]  = 1'b0;
         req_addr_d[d]   = '0;
         req_we_d[d]     = 1'b0;
         req_wdata_d[d]  = '0;
         req_wstrb_d[d]  = '0;
         resp_ready_d[d] = 1'b0;
      end
      test_reset();
      test_write_read();
      test_byte_strobe();
      test_backpressure();
      test_reset_mid_wait();
      test_addr_extremes();
      test_rd_latency1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
